// File: rtl/fb_read_dma_if.sv
// fb_read_dma_if: AXI3 read-address and read-data channel bundle used
// between the framebuffer read DMA (master) and the fpga2hps port (slave).
//   araddr/arlen/arsize/arburst/arcache/arvalid : AR channel, master -> slave
//   arready                                     : AR channel, slave -> master
//   rdata/rvalid/rlast/rresp                    : R channel, slave -> master
//   rready                                      : R channel, master -> slave
interface fb_read_dma_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    input  arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    output arready, rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/fb_read_dma.sv
// fb_read_dma: framebuffer read DMA. Streams a linear 32 bpp frame from DRAM
// with fixed-length INCR bursts (wrapping at the frame end), buffers the
// returned beats in a pixel FIFO and presents them as a valid/ready stream.
// Bursts are only issued when FIFO space is reserved for every outstanding
// beat, so R data is always accepted.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : permits new burst issue (in-flight bursts still finish)
//   frame_start     : one-cycle pulse, restart at BASE_ADDR, discard stale data
//   axi             : AXI3 AR/R channels (master side)
//   pix_data/pix_valid/pix_ready : pixel stream out of the FIFO head
//   underflow       : sticky, consumer asked for a pixel while FIFO empty
//   resp_err        : sticky, an R beat carried a non-OKAY response
module fb_read_dma #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FRAME_BYTES = 1228800,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_start,
  fb_read_dma_if.master     axi,
  output logic [31:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              underflow,
  output logic              resp_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0]   BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0]   END_ADDR    = BASE_ADDR + 32'(FRAME_BYTES);
  localparam logic [CW-1:0] BURST_CNT   = CW'(BURST_LEN);
  localparam logic [3:0]    LAST_BEAT   = 4'(BURST_LEN - 1);

  typedef enum logic {S_IDLE, S_ADDR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   araddr_q;
  logic          restart_q;
  logic [CW-1:0] inflight, drop, fifo_count;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   credit_need;
  logic          issue, ar_hs, beat, push, pop;
  logic [3:0]    beat_idx;

  assign ar_hs = axi.arvalid && axi.arready;
  assign beat  = axi.rvalid;  // rready is constantly high

  // One extra bit so count + inflight + burst cannot wrap before the compare.
  assign credit_need = {1'b0, fifo_count} + {1'b0, inflight} + (CW+1)'(BURST_LEN);
  assign issue = (state == S_IDLE) && enable && !frame_start &&
                 (credit_need <= (CW+1)'(FIFO_DEPTH));

  // AR state machine
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue)       state_nxt = S_ADDR;
      S_ADDR:  if (axi.arready) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    axi.arvalid = (state == S_ADDR);
    axi.araddr  = araddr_q;
    axi.arlen   = LAST_BEAT;
    axi.arsize  = 3'b010;
    axi.arburst = 2'b01;
    axi.arcache = 4'b0011;
    axi.rready  = 1'b1;
  end

  // Address sequencing. A frame_start that arrives while a request is
  // pending cannot touch araddr (AXI stability), so it is remembered in
  // restart_q and applied when that request handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q  <= BASE_ADDR;
      restart_q <= 1'b0;
    end else if (ar_hs) begin
      restart_q <= 1'b0;
      if (restart_q || frame_start)
        araddr_q <= BASE_ADDR;
      else if (araddr_q + BURST_BYTES == END_ADDR)
        araddr_q <= BASE_ADDR;
      else
        araddr_q <= araddr_q + BURST_BYTES;
    end else if (frame_start) begin
      if (state == S_ADDR) restart_q <= 1'b1;
      else                 araddr_q  <= BASE_ADDR;
    end
  end

  // Credit and stale-beat accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + (issue ? BURST_CNT : '0) - (beat ? CW'(1) : '0);
      if (frame_start)
        drop <= inflight - (beat ? CW'(1) : '0);
      else if (beat && drop != '0)
        drop <= drop - CW'(1);
    end
  end

  // Pixel FIFO
  assign push = beat && (drop == '0) && !frame_start;
  assign pop  = pix_valid && pix_ready && !frame_start;

  always_comb begin
    pix_valid = (fifo_count != '0);
    pix_data  = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi.rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (enable && pix_ready && !pix_valid) underflow <= 1'b1;
      if (beat && axi.rresp != 2'b00)        resp_err  <= 1'b1;
    end
  end

  // Beat position within the current burst, used only to cross-check rlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx <= '0;
    end else begin
      if (beat)
        beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 4'd1;
      if (beat)
        assert (axi.rlast == (beat_idx == LAST_BEAT));
      if (push)
        assert (fifo_count < CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_fb_read_dma.sv
module tb_fb_read_dma;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          FB    = 512;
  localparam int          BL    = 16;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic pix_ready = 1'b0;
  logic [31:0] pix_data;
  logic pix_valid, underflow, resp_err;

  fb_read_dma_if axi();

  fb_read_dma #(.BASE_ADDR(BASE), .FRAME_BYTES(FB), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start), .axi(axi),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .underflow(underflow), .resp_err(resp_err));

  // Small-frame instance: only its AR address sequence is observed.
  fb_read_dma_if axi2();
  logic [31:0] pix_data2;
  logic pix_valid2, underflow2, resp_err2;

  fb_read_dma #(.BASE_ADDR(BASE), .FRAME_BYTES(128), .BURST_LEN(16), .FIFO_DEPTH(64)) dut_wrap (
    .clk(clk), .rst(rst), .enable(1'b1), .frame_start(1'b0), .axi(axi2),
    .pix_data(pix_data2), .pix_valid(pix_valid2), .pix_ready(1'b0),
    .underflow(underflow2), .resp_err(resp_err2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls (written by the main process only)
  int ar_mode = 0;    // 0 always ready, 1 held low, 2 random
  int r_gap_pct = 0;
  int err_req = 0;

  // Memory model and reference model state (written by the monitor only)
  logic [31:0] bq_addr[$];
  int          bq_rdy[$];
  int          beat_idx = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          stale = 0;
  logic [31:0] exp_ar = BASE;
  bit          restart = 0;
  bit          uf_m = 0, re_m = 0;
  bit          want_first = 0;
  logic [31:0] hs_log[$];
  logic [31:0] wrap_log[$];
  bit          prev_arvalid = 0, prev_enable = 0, prev_fs = 0;

  function automatic logic [31:0] hs_at(input int i);
    return (i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wrap_at(input int i);
    return (i < wrap_log.size()) ? wrap_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Monitor: compares outputs against the model, then advances the model by
  // the events that the coming rising edge will commit.
  always @(negedge clk) begin
    int outstanding;
    cyc++;
    if (rst) begin
      bq_addr.delete(); bq_rdy.delete(); beat_idx = 0;
      exp_q.delete(); stale = 0; exp_ar = BASE; restart = 0;
      uf_m = 0; re_m = 0; want_first = 0; hs_log.delete();
    end else begin
      outstanding = bq_addr.size() * BL - beat_idx;
      chk("rready", axi.rready, 1);
      chk("pix_valid", pix_valid, (exp_q.size() != 0));
      if (pix_valid && exp_q.size() != 0) chk("pix_data", pix_data, exp_q[0]);
      chk("underflow", underflow, uf_m);
      chk("resp_err", resp_err, re_m);
      chk("credit", (exp_q.size() + outstanding + (axi.arvalid ? BL : 0) <= DEPTH), 1);
      if (axi.arvalid) begin
        chk("araddr", axi.araddr, exp_ar);
        chk("ar_const", {axi.arlen, axi.arsize, axi.arburst, axi.arcache},
            {4'hF, 3'b010, 2'b01, 4'b0011});
      end
      if (axi.arvalid && !prev_arvalid) chk("ar_gate", (prev_enable && !prev_fs), 1);

      if (enable && pix_ready && exp_q.size() == 0) uf_m = 1;
      if (axi.rvalid && axi.rresp != 2'b00) re_m = 1;

      if (frame_start) begin
        stale = outstanding - (axi.rvalid ? 1 : 0) + (axi.arvalid ? BL : 0);
        exp_q.delete();
        if (axi.arvalid) restart = 1;
        else             exp_ar = BASE;
        want_first = 1;
      end else begin
        if (pix_valid && pix_ready && exp_q.size() != 0) begin
          if (want_first) begin
            chk("first_pix_after_fs", pix_data, BASE);
            want_first = 0;
          end
          void'(exp_q.pop_front());
        end
        if (axi.rvalid) begin
          if (stale > 0) stale--;
          else           exp_q.push_back(axi.rdata);
        end
      end

      if (axi.arvalid && axi.arready) begin
        hs_log.push_back(axi.araddr);
        bq_addr.push_back(axi.araddr);
        bq_rdy.push_back(cyc + 4);
        if (restart || frame_start) exp_ar = BASE;
        else exp_ar = BASE + 32'((int'(exp_ar - BASE) + BL * 4) % FB);
        restart = 0;
      end

      if (axi.rvalid) begin
        beat_idx++;
        if (beat_idx == BL) begin
          beat_idx = 0;
          void'(bq_addr.pop_front());
          void'(bq_rdy.pop_front());
        end
      end

      if (axi2.arvalid && axi2.arready && wrap_log.size() < 3)
        wrap_log.push_back(axi2.araddr);
    end
    prev_arvalid = rst ? 1'b0 : axi.arvalid;
    prev_enable  = enable;
    prev_fs      = frame_start;
  end

  // AXI slave driver: beat value = byte address, 4+ cycles after AR.
  int err_sent = 0;
  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      case (ar_mode)
        0:       axi.arready = 1'b1;
        1:       axi.arready = 1'b0;
        default: axi.arready = ($urandom_range(0, 99) < 60);
      endcase
      if (!rst && bq_addr.size() != 0 && cyc >= bq_rdy[0] &&
          $urandom_range(0, 99) >= r_gap_pct) begin
        axi.rvalid = 1'b1;
        axi.rdata  = bq_addr[0] + 32'(4 * beat_idx);
        axi.rlast  = (beat_idx == BL - 1);
        if (err_sent < err_req) begin
          axi.rresp = 2'b10;
          err_sent++;
        end else begin
          axi.rresp = 2'b00;
        end
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = $urandom;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
      end
    end
  end

  initial begin
    axi2.arready = 1'b1; axi2.rvalid = 1'b0; axi2.rdata = '0; axi2.rlast = 1'b0; axi2.rresp = 2'b00;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int cnt, base_n, waited;
    logic [31:0] held;

    // Reset state and initial fill
    tick(1);
    do_reset();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_araddr", axi.araddr, BASE);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_rready", axi.rready, 1);

    enable = 1'b1; pix_ready = 1'b0; ar_mode = 0; r_gap_pct = 0;
    tick(100);
    chk("fill_bursts", hs_log.size(), 4);
    chk("fill_ar0", hs_at(0), 32'h1000_0000);
    chk("fill_ar1", hs_at(1), 32'h1000_0040);
    chk("fill_ar2", hs_at(2), 32'h1000_0080);
    chk("fill_ar3", hs_at(3), 32'h1000_00C0);
    tick(20);
    chk("fill_ar_stopped", hs_log.size(), 4);
    chk("fill_model_count", exp_q.size(), 64);
    chk("fill_first_pix", pix_data, 32'h1000_0000);

    // Continuous streaming with frame wrap
    pix_ready = 1'b1;
    tick(300);
    chk("stream_reissue", (hs_log.size() > 4), 1);
    chk("stream_wrap_ar", hs_at(8), BASE);
    chk("stream_no_underflow", underflow, 0);

    // AR held off for 10 cycles
    ar_mode = 1;
    waited = 0;
    while (!axi.arvalid && waited < 100) begin tick(1); waited++; end
    chk("hold_arvalid_seen", axi.arvalid, 1);
    held = axi.araddr;
    cnt = hs_log.size();
    repeat (10) begin
      tick(1);
      chk("hold_araddr_stable", axi.araddr, held);
      chk("hold_arvalid", axi.arvalid, 1);
    end
    chk("hold_no_hs", hs_log.size(), cnt);
    ar_mode = 0;
    waited = 0;
    while (hs_log.size() < cnt + 2 && waited < 200) begin tick(1); waited++; end
    chk("hold_hs_addr", hs_at(cnt), held);
    chk("hold_next_addr", hs_at(cnt + 1), BASE + 32'((int'(held - BASE) + 64) % FB));

    // frame_start with data in flight and a pending request
    do_reset();
    enable = 1'b1; pix_ready = 1'b0; ar_mode = 0;
    waited = 0;
    while (hs_log.size() < 2 && waited < 50) begin tick(1); waited++; end
    ar_mode = 1;
    waited = 0;
    while (exp_q.size() < 20 && waited < 100) begin tick(1); waited++; end
    chk("fs_pending", axi.arvalid, 1);
    chk("fs_pending_addr", axi.araddr, 32'h1000_0080);
    base_n = hs_log.size();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk("fs_flush", pix_valid, 0);
    pix_ready = 1'b1;
    tick(3);
    ar_mode = 0;
    waited = 0;
    while (hs_log.size() < base_n + 2 && waited < 200) begin tick(1); waited++; end
    chk("fs_old_hs", hs_at(base_n), 32'h1000_0080);
    chk("fs_restart_hs", hs_at(base_n + 1), BASE);
    tick(60);
    chk("fs_first_pix_seen", want_first, 0);

    // Underflow, response error, enable low
    do_reset();
    enable = 1'b1; pix_ready = 1'b1;
    tick(3);
    chk("underflow_set", underflow, 1);
    err_req++;
    tick(60);
    chk("resp_err_set", resp_err, 1);
    chk("underflow_sticky", underflow, 1);
    enable = 1'b0;
    tick(40);
    cnt = hs_log.size();
    tick(60);
    chk("disabled_no_ar", hs_log.size(), cnt);
    chk("disabled_arvalid", axi.arvalid, 0);
    chk("disabled_drained", pix_valid, 0);

    // Randomised traffic
    do_reset();
    ar_mode = 2; r_gap_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(0, 99) < 90);
      pix_ready   = ($urandom_range(0, 99) < 70);
      frame_start = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) err_req++;
      if (i == 1500) do_reset();
      else tick(1);
    end
    frame_start = 1'b0;
    tick(5);

    chk("wrap_ar0", wrap_at(0), 32'h1000_0000);
    chk("wrap_ar1", wrap_at(1), 32'h1000_0040);
    chk("wrap_ar2", wrap_at(2), 32'h1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
